// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Round-robin RAM port arbiter between ICache and LSB that
//               serialises each access into little-endian byte cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full,
    input  logic        ic_enable,
    input  logic [31:0] ic_addr,
    output logic        ic_valid,
    output logic [31:0] ic_data,
    input  logic        lsb_enable,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_din,
    output logic        lsb_valid,
    output logic [31:0] lsb_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    state_t      r_state,    w_state_nxt;
    logic [31:0] r_addr,     w_addr_nxt;
    logic [31:0] r_din,      w_din_nxt;
    logic [31:0] r_buf,      w_buf_nxt;
    logic [2:0]  r_len,      w_len_nxt;
    logic [2:0]  r_cnt,      w_cnt_nxt;
    logic        r_last_ic,  w_last_ic_nxt;
    logic [31:0] r_ram_a,    w_ram_a_nxt;
    logic [7:0]  r_ram_dout, w_ram_dout_nxt;
    logic        r_ram_wr,   w_ram_wr_nxt;
    logic        r_ic_valid, w_ic_valid_nxt;
    logic [31:0] r_ic_data,  w_ic_data_nxt;
    logic        r_lsb_valid, w_lsb_valid_nxt;
    logic [31:0] r_lsb_dout, w_lsb_dout_nxt;

    // w_edge numbers the edge about to happen, counted from the grant edge
    logic [2:0]  w_edge;
    logic [31:0] w_addr_step;
    logic [31:0] w_byte_pos;
    logic [31:0] w_merged;
    logic [7:0]  w_store_byte;
    logic        w_io_blocked;
    logic        w_lsb_req;
    logic        w_can_grant;
    logic [2:0]  w_lsb_len;

    assign w_edge       = r_cnt + 3'd1;
    assign w_addr_step  = r_addr + {29'd0, w_edge};
    assign w_byte_pos   = {24'd0, ram_din} << {w_edge - 3'd2, 3'b000};
    assign w_merged     = r_buf | w_byte_pos;
    assign w_store_byte = r_din[{w_edge[1:0], 3'b000} +: 8];
    assign w_io_blocked = lsb_wr && (lsb_addr[17:16] == 2'b11) && io_buffer_full;
    assign w_lsb_req    = lsb_enable && !w_io_blocked;
    // A still-high valid means the client has not yet dropped its request
    assign w_can_grant  = !flush && !r_ic_valid && !r_lsb_valid;
    assign w_lsb_len    = (lsb_len == 2'b00) ? 3'd1 :
                          (lsb_len == 2'b01) ? 3'd2 : 3'd4;

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_din_nxt       = r_din;
        w_buf_nxt       = r_buf;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_last_ic_nxt   = r_last_ic;
        w_ram_a_nxt     = r_ram_a;
        w_ram_dout_nxt  = r_ram_dout;
        w_ram_wr_nxt    = r_ram_wr;
        w_ic_valid_nxt  = 1'b0;
        w_ic_data_nxt   = r_ic_data;
        w_lsb_valid_nxt = 1'b0;
        w_lsb_dout_nxt  = r_lsb_dout;

        case (r_state)
            S_IDLE: begin
                if (w_can_grant) begin
                    if (w_lsb_req && (!ic_enable || r_last_ic)) begin
                        w_addr_nxt    = lsb_addr;
                        w_din_nxt     = lsb_din;
                        w_len_nxt     = w_lsb_len;
                        w_cnt_nxt     = 3'd0;
                        w_buf_nxt     = 32'd0;
                        w_last_ic_nxt = 1'b0;
                        w_ram_a_nxt   = lsb_addr;
                        if (lsb_wr) begin
                            w_state_nxt    = S_STORE;
                            w_ram_wr_nxt   = 1'b1;
                            w_ram_dout_nxt = lsb_din[7:0];
                        end else begin
                            w_state_nxt    = S_LOAD;
                        end
                    end else if (ic_enable) begin
                        w_state_nxt   = S_FETCH;
                        w_addr_nxt    = ic_addr;
                        w_len_nxt     = 3'd4;
                        w_cnt_nxt     = 3'd0;
                        w_buf_nxt     = 32'd0;
                        w_last_ic_nxt = 1'b1;
                        w_ram_a_nxt   = ic_addr;
                    end
                end
            end
            S_FETCH, S_LOAD: begin
                if (flush) begin
                    w_state_nxt  = S_IDLE;
                    w_ram_wr_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_edge;
                    if (w_edge < r_len)
                        w_ram_a_nxt = w_addr_step;
                    // RAM answers one cycle late, so byte k lands at edge k+2
                    if (w_edge >= 3'd2)
                        w_buf_nxt = w_merged;
                    if (w_edge == r_len + 3'd1) begin
                        w_state_nxt = S_IDLE;
                        if (r_state == S_FETCH) begin
                            w_ic_valid_nxt  = 1'b1;
                            w_ic_data_nxt   = w_merged;
                        end else begin
                            w_lsb_valid_nxt = 1'b1;
                            w_lsb_dout_nxt  = w_merged;
                        end
                    end
                end
            end
            S_STORE: begin
                w_cnt_nxt = w_edge;
                if (w_edge == r_len) begin
                    w_state_nxt     = S_IDLE;
                    w_ram_wr_nxt    = 1'b0;
                    w_lsb_valid_nxt = 1'b1;
                end else begin
                    w_ram_a_nxt     = w_addr_step;
                    w_ram_dout_nxt  = w_store_byte;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_ram_wr_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'd0;
            r_din       <= 32'd0;
            r_buf       <= 32'd0;
            r_len       <= 3'd0;
            r_cnt       <= 3'd0;
            r_last_ic   <= 1'b1;
            r_ram_a     <= 32'd0;
            r_ram_dout  <= 8'd0;
            r_ram_wr    <= 1'b0;
            r_ic_valid  <= 1'b0;
            r_ic_data   <= 32'd0;
            r_lsb_valid <= 1'b0;
            r_lsb_dout  <= 32'd0;
        end else if (rdy) begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_din       <= w_din_nxt;
            r_buf       <= w_buf_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last_ic   <= w_last_ic_nxt;
            r_ram_a     <= w_ram_a_nxt;
            r_ram_dout  <= w_ram_dout_nxt;
            r_ram_wr    <= w_ram_wr_nxt;
            r_ic_valid  <= w_ic_valid_nxt;
            r_ic_data   <= w_ic_data_nxt;
            r_lsb_valid <= w_lsb_valid_nxt;
            r_lsb_dout  <= w_lsb_dout_nxt;
        end
    end

    assign ram_a     = r_ram_a;
    assign ram_dout  = r_ram_dout;
    assign ram_wr    = r_ram_wr;
    assign ic_valid  = r_ic_valid;
    assign ic_data   = r_ic_data;
    assign lsb_valid = r_lsb_valid;
    assign lsb_dout  = r_lsb_dout;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Scoreboard bench for mem_ctrl with a registered-read RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic [7:0]  ram_din = 8'd0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full;
    logic        ic_enable;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_data;
    logic        lsb_enable;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_din;
    logic        lsb_valid;
    logic [31:0] lsb_dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_ic[$];
    logic [39:0] exp_wr[$];
    logic        exp_src[$];
    logic [31:0] exp_dat[$];

    logic [31:0] s_ram_a;
    logic [7:0]  s_ram_dout;
    logic        s_ram_wr, s_ic_valid, s_lsb_valid, s_rdy;
    logic [31:0] s_ic_data, s_lsb_dout;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full),
        .ic_enable(ic_enable), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_data(ic_data),
        .lsb_enable(lsb_enable), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_din(lsb_din), .lsb_valid(lsb_valid), .lsb_dout(lsb_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h1000: rom = 8'h13;
            32'h1001: rom = 8'h05;
            32'h1002: rom = 8'h00;
            32'h1003: rom = 8'h00;
            default:  rom = a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        rom_word = {rom(a + 32'd3), rom(a + 32'd2), rom(a + 32'd1), rom(a)};
    endfunction

    // Registered-read RAM that stalls with the rest of the CPU
    always @(posedge clk) if (rdy) ram_din <= rom(ram_a);

    // Sample the cycle at the falling edge, then advance past the next rising edge
    task automatic tick();
        @(negedge clk);
        s_ram_a = ram_a; s_ram_dout = ram_dout; s_ram_wr = ram_wr;
        s_ic_valid = ic_valid; s_ic_data = ic_data;
        s_lsb_valid = lsb_valid; s_lsb_dout = lsb_dout; s_rdy = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        ic_enable = 1'b0; ic_addr = 32'd0; lsb_enable = 1'b0; lsb_wr = 1'b0;
        lsb_addr = 32'd0; lsb_len = 2'd0; lsb_din = 32'd0;
        repeat (3) tick();
        checks++; if (ram_a !== 32'd0) begin errors++; $display("FAIL reset_ram_a got=%h exp=0", ram_a); end
        checks++; if (ram_dout !== 8'd0) begin errors++; $display("FAIL reset_ram_dout got=%h exp=0", ram_dout); end
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL reset_ram_wr got=%b exp=0", ram_wr); end
        checks++; if ({ic_valid, lsb_valid} !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", {ic_valid, lsb_valid}); end
        checks++; if ({ic_data, lsb_dout} !== 64'd0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", ic_data, lsb_dout); end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_fetch();
        logic [31:0] e;
        int t_valid, nval;
        repeat (2) tick();
        exp_ic.push_back(32'h0000_0513);
        ic_addr = 32'h1000; ic_enable = 1'b1;
        t_valid = -1; nval = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t >= 2 && t <= 5) begin
                checks++;
                if (s_ram_a !== 32'h1000 + 32'(t - 2) || s_ram_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_addr t=%0d got a=%h wr=%b exp a=%h wr=0", t, s_ram_a, s_ram_wr, 32'h1000 + 32'(t - 2));
                end
            end
            if (s_ic_valid && s_rdy) begin
                nval++;
                if (t_valid < 0) t_valid = t;
                checks++;
                if (exp_ic.size() == 0) begin
                    errors++; $display("FAIL fetch_data got=%h exp=<none>", s_ic_data);
                end else begin
                    e = exp_ic.pop_front();
                    if (s_ic_data !== e) begin errors++; $display("FAIL fetch_data got=%h exp=%h", s_ic_data, e); end
                end
                ic_enable = 1'b0;
            end
        end
        checks++; if (t_valid != 7) begin errors++; $display("FAIL fetch_latency got tick=%0d exp tick=7", t_valid); end
        checks++; if (nval != 1) begin errors++; $display("FAIL fetch_pulses got=%0d exp=1", nval); end
        ic_enable = 1'b0; exp_ic.delete();
    endtask

    task automatic test_store_half();
        logic [39:0] e;
        int t_valid, nval;
        repeat (2) tick();
        exp_wr.push_back({32'h2002, 8'h34});
        exp_wr.push_back({32'h2003, 8'h12});
        lsb_addr = 32'h2002; lsb_wr = 1'b1; lsb_len = 2'b01; lsb_din = 32'hABCD1234; lsb_enable = 1'b1;
        t_valid = -1; nval = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (s_ram_wr && s_rdy) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++; $display("FAIL store_half_wr got=%h/%h exp=<none>", s_ram_a, s_ram_dout);
                end else begin
                    e = exp_wr.pop_front();
                    if ({s_ram_a, s_ram_dout} !== e) begin errors++; $display("FAIL store_half_wr got=%h/%h exp=%h/%h", s_ram_a, s_ram_dout, e[39:8], e[7:0]); end
                end
            end
            if (s_lsb_valid && s_rdy) begin
                nval++;
                if (t_valid < 0) t_valid = t;
                checks++; if (s_ram_wr !== 1'b0) begin errors++; $display("FAIL store_half_wr_end got=%b exp=0", s_ram_wr); end
                lsb_enable = 1'b0;
            end
        end
        checks++; if (t_valid != 4 || nval != 1) begin errors++; $display("FAIL store_half_valid got tick=%0d n=%0d exp tick=4 n=1", t_valid, nval); end
        checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL store_half_missing got left=%0d exp=0", exp_wr.size()); end
        lsb_enable = 1'b0; lsb_wr = 1'b0; exp_wr.delete();
    endtask

    task automatic test_arbitration();
        logic src;
        logic [31:0] d, got_d;
        int nv;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int ph = 0; ph < 2; ph++) begin
            exp_src.push_back(1'b0); exp_dat.push_back({24'd0, rom(32'h40 + 32'(ph))});
            exp_src.push_back(1'b1); exp_dat.push_back(rom_word(32'h100 + 32'(4 * ph)));
            lsb_addr = 32'h40 + 32'(ph); lsb_wr = 1'b0; lsb_len = 2'b00; lsb_enable = 1'b1;
            ic_addr = 32'h100 + 32'(4 * ph); ic_enable = 1'b1;
            nv = 0;
            for (int t = 0; t < 30 && nv < 2; t++) begin
                tick();
                if (s_rdy && (s_lsb_valid || s_ic_valid)) begin
                    nv++;
                    checks++;
                    got_d = s_ic_valid ? s_ic_data : s_lsb_dout;
                    if (exp_src.size() == 0) begin
                        errors++; $display("FAIL arb_order ph=%0d got ic=%b lsb=%b exp=<none>", ph, s_ic_valid, s_lsb_valid);
                    end else begin
                        src = exp_src.pop_front(); d = exp_dat.pop_front();
                        if ({s_ic_valid, s_lsb_valid} !== {src, ~src} || got_d !== d) begin
                            errors++;
                            $display("FAIL arb_order ph=%0d got ic=%b lsb=%b data=%h exp ic=%b data=%h", ph, s_ic_valid, s_lsb_valid, got_d, src, d);
                        end
                    end
                    if (s_lsb_valid) lsb_enable = 1'b0;
                    if (s_ic_valid) ic_enable = 1'b0;
                end
            end
            checks++; if (nv != 2) begin errors++; $display("FAIL arb_complete ph=%0d got=%0d exp=2", ph, nv); end
            lsb_enable = 1'b0; ic_enable = 1'b0;
            exp_src.delete(); exp_dat.delete();
            repeat (2) tick();
        end
    endtask

    task automatic test_flush();
        logic [39:0] e;
        int nval, nwr;
        repeat (2) tick();
        ic_addr = 32'h1000; ic_enable = 1'b1;
        nval = 0; nwr = 0;
        for (int t = 1; t <= 14; t++) begin
            if (t == 3) begin flush = 1'b1; ic_enable = 1'b0; end
            tick();
            flush = 1'b0;
            if (s_ic_valid && s_rdy) nval++;
            if (s_ram_wr) nwr++;
        end
        checks++; if (nval != 0 || nwr != 0) begin errors++; $display("FAIL flush_fetch got valid=%0d wr=%0d exp 0/0", nval, nwr); end
        test_fetch();
        // a flush during a store must not cut the write short
        repeat (2) tick();
        for (int k = 0; k < 4; k++) exp_wr.push_back({32'h500 + 32'(k), 8'(32'hDEADBEEF >> (8 * k))});
        lsb_addr = 32'h500; lsb_wr = 1'b1; lsb_len = 2'b10; lsb_din = 32'hDEADBEEF; lsb_enable = 1'b1;
        nval = 0;
        for (int t = 1; t <= 12; t++) begin
            flush = (t == 3);
            tick();
            if (s_ram_wr && s_rdy) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++; $display("FAIL flush_store_wr got=%h/%h exp=<none>", s_ram_a, s_ram_dout);
                end else begin
                    e = exp_wr.pop_front();
                    if ({s_ram_a, s_ram_dout} !== e) begin errors++; $display("FAIL flush_store_wr got=%h/%h exp=%h/%h", s_ram_a, s_ram_dout, e[39:8], e[7:0]); end
                end
            end
            if (s_lsb_valid && s_rdy) begin nval++; lsb_enable = 1'b0; end
        end
        flush = 1'b0;
        checks++; if (nval != 1 || exp_wr.size() != 0) begin errors++; $display("FAIL flush_store_done got valid=%0d left=%0d exp 1/0", nval, exp_wr.size()); end
        lsb_enable = 1'b0; lsb_wr = 1'b0; exp_wr.delete();
    endtask

    task automatic test_io_gate();
        logic [39:0] e;
        logic [31:0] ei;
        int nwr, nic, nv;
        repeat (2) tick();
        exp_ic.push_back(32'h0000_0513);
        io_buffer_full = 1'b1;
        lsb_addr = 32'h0003_0000; lsb_wr = 1'b1; lsb_len = 2'b00; lsb_din = 32'h0000_0077; lsb_enable = 1'b1;
        ic_addr = 32'h1000; ic_enable = 1'b1;
        nwr = 0; nic = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (s_ram_wr) nwr++;
            if (s_ic_valid && s_rdy) begin
                nic++;
                checks++;
                if (exp_ic.size() == 0) begin
                    errors++; $display("FAIL io_fetch_data got=%h exp=<none>", s_ic_data);
                end else begin
                    ei = exp_ic.pop_front();
                    if (s_ic_data !== ei) begin errors++; $display("FAIL io_fetch_data got=%h exp=%h", s_ic_data, ei); end
                end
                ic_enable = 1'b0;
            end
        end
        checks++; if (nwr != 0) begin errors++; $display("FAIL io_gate_wr got=%0d exp=0", nwr); end
        checks++; if (nic != 1) begin errors++; $display("FAIL io_fetch_done got=%0d exp=1", nic); end
        io_buffer_full = 1'b0;
        exp_wr.push_back({32'h0003_0000, 8'h77});
        nv = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (s_ram_wr && s_rdy) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++; $display("FAIL io_store_wr got=%h/%h exp=<none>", s_ram_a, s_ram_dout);
                end else begin
                    e = exp_wr.pop_front();
                    if ({s_ram_a, s_ram_dout} !== e) begin errors++; $display("FAIL io_store_wr got=%h/%h exp=%h/%h", s_ram_a, s_ram_dout, e[39:8], e[7:0]); end
                end
            end
            if (s_lsb_valid && s_rdy) begin nv++; lsb_enable = 1'b0; end
        end
        checks++; if (nv != 1 || exp_wr.size() != 0) begin errors++; $display("FAIL io_store_done got valid=%0d left=%0d exp 1/0", nv, exp_wr.size()); end
        lsb_enable = 1'b0; lsb_wr = 1'b0; ic_enable = 1'b0; exp_wr.delete(); exp_ic.delete();
    endtask

    task automatic test_rdy_stall();
        logic [31:0] ei;
        int t_valid, nval;
        repeat (2) tick();
        exp_ic.push_back(rom_word(32'h2000));
        ic_addr = 32'h2000; ic_enable = 1'b1;
        t_valid = -1; nval = 0;
        for (int t = 1; t <= 14; t++) begin
            rdy = !(t >= 3 && t <= 5);
            tick();
            if (s_ic_valid && s_rdy) begin
                nval++;
                if (t_valid < 0) t_valid = t;
                checks++;
                if (exp_ic.size() == 0) begin
                    errors++; $display("FAIL stall_data got=%h exp=<none>", s_ic_data);
                end else begin
                    ei = exp_ic.pop_front();
                    if (s_ic_data !== ei) begin errors++; $display("FAIL stall_data got=%h exp=%h", s_ic_data, ei); end
                end
                ic_enable = 1'b0;
            end
        end
        rdy = 1'b1;
        checks++; if (t_valid != 10 || nval != 1) begin errors++; $display("FAIL stall_latency got tick=%0d n=%0d exp tick=10 n=1", t_valid, nval); end
        ic_enable = 1'b0; exp_ic.delete();
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] el;
        int t_valid;
        repeat (2) tick();
        lsb_addr = 32'h600; lsb_wr = 1'b1; lsb_len = 2'b10; lsb_din = 32'h11223344; lsb_enable = 1'b1;
        repeat (3) tick();
        checks++; if (ram_wr !== 1'b1 || ram_a !== 32'h602) begin errors++; $display("FAIL rst_pre_wr got wr=%b a=%h exp wr=1 a=00000602", ram_wr, ram_a); end
        rst = 1'b1;
        #1;
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL rst_async_wr got=%b exp=0", ram_wr); end
        checks++;
        if ({ram_a, ram_dout, ic_valid, lsb_valid, ic_data, lsb_dout} !== 106'd0) begin
            errors++; $display("FAIL rst_async_outputs got a=%h d=%h v=%b%b ic=%h lsb=%h exp all 0", ram_a, ram_dout, ic_valid, lsb_valid, ic_data, lsb_dout);
        end
        lsb_enable = 1'b0; lsb_wr = 1'b0;
        tick();
        checks++; if (s_lsb_valid !== 1'b0) begin errors++; $display("FAIL rst_no_valid got=%b exp=0", s_lsb_valid); end
        rst = 1'b0;
        tick();
        exp_dat.push_back({24'd0, rom(32'h42)});
        lsb_addr = 32'h42; lsb_len = 2'b00; lsb_enable = 1'b1;
        t_valid = -1;
        for (int t = 1; t <= 10 && t_valid < 0; t++) begin
            tick();
            if (s_lsb_valid && s_rdy) begin
                t_valid = t;
                checks++;
                if (exp_dat.size() == 0) begin
                    errors++; $display("FAIL rst_fresh_load got=%h exp=<none>", s_lsb_dout);
                end else begin
                    el = exp_dat.pop_front();
                    if (s_lsb_dout !== el) begin errors++; $display("FAIL rst_fresh_load got=%h exp=%h", s_lsb_dout, el); end
                end
                lsb_enable = 1'b0;
            end
        end
        checks++; if (t_valid != 4) begin errors++; $display("FAIL rst_fresh_latency got tick=%0d exp tick=4", t_valid); end
        lsb_enable = 1'b0; exp_dat.delete();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_half();
        test_arbitration();
        test_flush();
        test_io_gate();
        test_rdy_stall();
        test_reset_mid_store();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
